ws2812_bit_encoder: RTL
=======================

Name: ws2812_bit_encoder

Overview:
- Downstream stage of the WS2812 APB register block.
- Takes 24-bit GRB pixel words over a valid/ready handshake and drives the single-wire WS2812 NRZ waveform on led_o.
- Sends bits MSB first with programmable high/low timing.
- After the pixel flagged last, holds the line low for the latch/reset period, then pulses done_o.

Parameters:
- T0H_CYC, 20: high-time cycles for a 0 bit (0.4 us at 50 MHz).
- T1H_CYC, 40: high-time cycles for a 1 bit (0.8 us at 50 MHz).
- TBIT_CYC, 63: total bit period in cycles (1.26 us at 50 MHz); must satisfy TBIT_CYC > T1H_CYC > T0H_CYC >= 1.
- TRST_CYC, 15000: latch low-time cycles after the last pixel (300 us at 50 MHz).
- CNT_W, 16: timing counter width; must hold TRST_CYC.

Ports:
- clk_i  in  1  clock.
- resetn_i  in  1  reset, asynchronous, active-low.
- pix_data_i  in  24 (32 with WS2812_RGBW_EN)  pixel word; bit 23 = G7 is sent first.
- pix_last_i  in  1  marks the pixel as the last of the frame; sampled with pix_data_i.
- pix_valid_i  in  1  upstream pixel valid.
- pix_ready_o  out  1  encoder can accept a pixel this cycle.
- led_o  out  1  registered serial output to the LED strip.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse when the latch period completes.

Behaviour:
- Reset (async, resetn_i low): state = IDLE, led_o = 0, done_o = 0, shift register = 0, counters = 0, last flag = 0. A reset mid-bit or mid-latch forces led_o low immediately.
- States: IDLE, HIGH, LOW, LATCH.
- Transfer occurs when pix_valid_i & pix_ready_o at a rising edge. It loads the shift register from pix_data_i, the last flag from pix_last_i, and bit_idx = NBITS-1 (NBITS = 24, or 32 with the macro).
- pix_ready_o is combinational:
  - 1 in IDLE;
  - 1 in LOW only on the final cycle of the final bit (bit_idx == 0, cnt == 1) when the last flag is 0;
  - 0 otherwise.
- IDLE: led_o = 0. On transfer -> HIGH; led_o = 1 from the next cycle.
- HIGH: led_o = 1 for exactly T1H_CYC cycles if the current bit is 1, else T0H_CYC cycles. Then -> LOW.
- LOW: led_o = 0 for TBIT_CYC - THx cycles, so the bit period is exactly TBIT_CYC. At the end of LOW:
  - bit_idx > 0: decrement, shift left, -> HIGH.
  - bit_idx == 0 and transfer this cycle: -> HIGH with the new pixel (zero-gap back-to-back).
  - bit_idx == 0, no transfer, last flag = 1: -> LATCH.
  - bit_idx == 0, no transfer, last flag = 0: -> IDLE. This is an upstream underrun; the line stays low and the strip may latch early. That is upstream's responsibility.
- LATCH: led_o = 0 for TRST_CYC cycles, then -> IDLE with done_o = 1 for one cycle (coincident with the IDLE entry).
  - No pixel is accepted during LATCH.
  - A new frame may be accepted in the cycle after done_o.
- Latency: led_o rises 1 cycle after the accepting edge.
- The timing counter is a load-and-count-down counter, CNT_W bits. No arithmetic wrap is permitted; parameter limits guarantee this.
- pix_data_i is don't-care when pix_valid_i = 0. Holding pix_valid_i high with ready low must not change state.

Optional Feature:
- Macro WS2812_RGBW_EN.
- Defined: pixel width 32 (GRBW, bit 31 sent first), NBITS = 32, for SK6812 RGBW strips.
- Undefined: 24-bit GRB, NBITS = 24, pix_data_i is 24 bits wide.
- Timing and state machine are identical in both builds.

Test Plan:
- Single pixel 0x800001, last = 1:
  - led_o: first high = 40 cycles, then 23 low.
  - Bits 22..1: 20 high / 43 low each.
  - Bit 0: 40 high / 23 low.
  - Then 15000 cycles low, done_o pulses once, busy_o falls in the same cycle done_o rises.
- Two pixels 0xFFFFFF then 0x000000 (last): valid held high.
  - Second transfer occurs on the final cycle of bit 0 of the first.
  - No extra low cycles between pixels: 63-cycle periods throughout.
  - 48 bits total before LATCH.
- Underrun: pixel 0x0F0F0F with last = 0, then valid = 0.
  - After 24 bits, state -> IDLE, led_o = 0, busy_o = 0, done_o never pulses.
- Backpressure: valid asserted mid-pixel.
  - pix_ready_o stays 0 until the final cycle of bit 0.
  - Data changed while ready = 0 is ignored.
  - During LATCH, ready = 0 for all 15000 cycles.
- Reset mid-operation: assert resetn_i low during a HIGH phase.
  - led_o = 0, busy_o = 0 asynchronously.
  - After release, state is IDLE and pix_ready_o = 1.
- WS2812_RGBW_EN defined: pixel 0x80000001 (last = 1).
  - 32 bit periods: bits 31 and 0 long-high, the rest short-high.
  - Then latch and done_o.

Source files
------------

// File: rtl/ws2812_bit_encoder.sv
// WS2812 single-wire NRZ encoder: streams GRB pixel words MSB first, then holds the latch low time.
// Define WS2812_RGBW_EN for 32-bit GRBW pixels (SK6812 RGBW strips).
module ws2812_bit_encoder #(
    parameter int T0H_CYC  = 20,
    parameter int T1H_CYC  = 40,
    parameter int TBIT_CYC = 63,
    parameter int TRST_CYC = 15000,
    parameter int CNT_W    = 16
) (
    input  logic        clk_i,
    input  logic        resetn_i,
`ifdef WS2812_RGBW_EN
    input  logic [31:0] pix_data_i,
`else
    input  logic [23:0] pix_data_i,
`endif
    input  logic        pix_last_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic        led_o,
    output logic        busy_o,
    output logic        done_o
);

`ifdef WS2812_RGBW_EN
    localparam int NBITS = 32;
`else
    localparam int NBITS = 24;
`endif
    localparam int IDX_W = $clog2(NBITS);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TBIT = CNT_W'(TBIT_CYC);
    localparam logic [CNT_W-1:0] CNT_TRST = CNT_W'(TRST_CYC);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t             state, state_n;
    logic [NBITS-1:0]   shreg, shreg_n;
    logic [IDX_W-1:0]   bit_idx, bit_idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               last_flag, last_n;
    logic               done_n;
    logic               xfer;

    function automatic logic [CNT_W-1:0] high_time(input logic b);
        return b ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
    endfunction

    // Ready opens only on the very last cycle of a pixel so the next one starts with no gap
    assign pix_ready_o = (state == IDLE) ||
                         (state == LOW && bit_idx == '0 && cnt == CNT_ONE && !last_flag);
    assign xfer   = pix_valid_i && pix_ready_o;
    assign busy_o = (state != IDLE);

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        cnt_n     = cnt;
        last_n    = last_flag;
        done_n    = 1'b0;
        if (xfer) begin
            state_n   = HIGH;
            shreg_n   = pix_data_i;
            last_n    = pix_last_i;
            bit_idx_n = IDX_TOP;
            cnt_n     = high_time(pix_data_i[NBITS-1]);
        end else begin
            case (state)
                HIGH: begin
                    if (cnt == CNT_ONE) begin
                        state_n = LOW;
                        cnt_n   = CNT_TBIT - high_time(shreg[NBITS-1]);
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                LOW: begin
                    if (cnt != CNT_ONE) begin
                        cnt_n = cnt - CNT_ONE;
                    end else if (bit_idx != '0) begin
                        state_n   = HIGH;
                        bit_idx_n = bit_idx - IDX_ONE;
                        shreg_n   = shreg << 1;
                        cnt_n     = high_time(shreg[NBITS-2]);
                    end else if (last_flag) begin
                        state_n = LATCH;
                        cnt_n   = CNT_TRST;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                LATCH: begin
                    if (cnt == CNT_ONE) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // led_o is registered from the next state so the line is high exactly while in HIGH
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            cnt       <= '0;
            last_flag <= 1'b0;
            led_o     <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_idx   <= bit_idx_n;
            cnt       <= cnt_n;
            last_flag <= last_n;
            led_o     <= (state_n == HIGH);
            done_o    <= done_n;
        end
    end

endmodule
